// File: rtl/systolic_array_pkg.sv
// Shared fixed-point types and MAC helpers for the TPU systolic array.
// Build option: define SYSTOLIC_SAT_EN to saturate the MAC instead of wrapping.
package tpu_pkg;

  localparam int TPU_DATA_W = 16;
  localparam int TPU_FRAC_W = 8;

  typedef logic signed [TPU_DATA_W-1:0] fixed_t;

  // Reduce a wide value to its low dw bits, sign-extended back to 64 bits.
  function automatic logic signed [63:0] fx_wrap(input logic signed [63:0] x, input int dw);
    return (x <<< (64 - dw)) >>> (64 - dw);
  endfunction

  function automatic logic signed [63:0] fx_clamp(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Width-generic MAC, valid for data widths up to 32 bits.
  function automatic logic signed [63:0] fx_mac_w(
    input logic signed [63:0] psum,
    input logic signed [63:0] a,
    input logic signed [63:0] w,
    input int                 dw,
    input int                 fw
  );
    logic signed [63:0] prod;
    prod = (a * w) >>> fw;
`ifdef SYSTOLIC_SAT_EN
    return fx_clamp(psum + fx_clamp(prod, dw), dw);
`else
    return fx_wrap(psum + fx_wrap(prod, dw), dw);
`endif
  endfunction

  function automatic fixed_t fx_mac(input fixed_t psum, input fixed_t a, input fixed_t w);
    return fixed_t'(fx_mac_w(64'(psum), 64'(a), 64'(w), TPU_DATA_W, TPU_FRAC_W));
  endfunction

endpackage

// File: rtl/systolic_array_if.sv
// Unified-buffer side bundle of the systolic array: west/north feeds, column size, south psums.
interface systolic_array_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16
);
  localparam int COL_SIZE_W = $clog2(COLS + 1);

  logic [ROWS*DATA_W-1:0] sys_data_in;
  logic [ROWS-1:0]        sys_valid_in;
  logic [COLS*DATA_W-1:0] sys_weight_in;
  logic [COLS-1:0]        sys_accept_w;
  logic                   sys_switch_in;
  logic [COL_SIZE_W-1:0]  ub_rd_col_size_in;
  logic                   ub_rd_col_size_valid_in;
  logic [COLS*DATA_W-1:0] sys_data_out;
  logic [COLS-1:0]        sys_valid_out;

  modport master (
    output sys_data_in, sys_valid_in, sys_weight_in, sys_accept_w, sys_switch_in,
    output ub_rd_col_size_in, ub_rd_col_size_valid_in,
    input  sys_data_out, sys_valid_out
  );

  modport slave (
    input  sys_data_in, sys_valid_in, sys_weight_in, sys_accept_w, sys_switch_in,
    input  ub_rd_col_size_in, ub_rd_col_size_valid_in,
    output sys_data_out, sys_valid_out
  );

endinterface

// File: rtl/systolic_array_pe.sv
// One weight-stationary cell: shadow/active weight pair, switch hop register and the MAC.
// The MAC follows SYSTOLIC_SAT_EN through the tpu_pkg helpers.
module systolic_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W,
  parameter int FRAC_W = TPU_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              col_en,
  input  logic [DATA_W-1:0] act_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] psum_in,
  input  logic              switch_in,
  input  logic              accept,
  input  logic [DATA_W-1:0] shadow_in,
  output logic [DATA_W-1:0] act_out,
  output logic              valid_east,
  output logic [DATA_W-1:0] psum_out,
  output logic              valid_south,
  output logic [DATA_W-1:0] shadow_out,
  output logic              switch_out
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] act_q, act_d;
  logic [DATA_W-1:0] psum_q, psum_d;
  logic              valid_e_q, valid_e_d;
  logic              valid_s_q, valid_s_d;
  logic              switch_q, switch_d;
  logic [DATA_W-1:0] weight_eff;
  logic [DATA_W-1:0] mac_sum;

  // On the switch edge the incoming shadow weight already drives this edge's MAC.
  assign weight_eff = switch_in ? shadow_q : active_q;

  if (DATA_W == TPU_DATA_W && FRAC_W == TPU_FRAC_W) begin : g_pkg_mac
    assign mac_sum = fx_mac(psum_in, act_in, weight_eff);
  end else begin : g_generic_mac
    assign mac_sum = DATA_W'(fx_mac_w(64'($signed(psum_in)), 64'($signed(act_in)),
                                      64'($signed(weight_eff)), DATA_W, FRAC_W));
  end

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    act_d     = act_in;
    valid_e_d = valid_in;
    switch_d  = switch_in;
    psum_d    = '0;
    valid_s_d = 1'b0;
    if (accept) shadow_d = shadow_in;
    if (switch_in) active_d = shadow_q;
    if (valid_in && col_en) begin
      psum_d    = mac_sum;
      valid_s_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      active_q  <= '0;
      act_q     <= '0;
      psum_q    <= '0;
      valid_e_q <= 1'b0;
      valid_s_q <= 1'b0;
      switch_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      act_q     <= act_d;
      psum_q    <= psum_d;
      valid_e_q <= valid_e_d;
      valid_s_q <= valid_s_d;
      switch_q  <= switch_d;
    end
  end

  assign act_out     = act_q;
  assign valid_east  = valid_e_q;
  assign psum_out    = psum_q;
  assign valid_south = valid_s_q;
  assign shadow_out  = shadow_q;
  assign switch_out  = switch_q;

endmodule

// File: rtl/systolic_array.sv
// Weight-stationary ROWS x COLS systolic array: column-enable mask and PE grid wiring.
// Build option SYSTOLIC_SAT_EN selects saturating MACs in every PE.
module systolic_array
  import tpu_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = TPU_DATA_W,
  parameter int FRAC_W = TPU_FRAC_W
) (
  input logic             clk,
  input logic             rst,
  systolic_array_if.slave bus
);

  logic [COLS-1:0] col_mask_q, col_mask_d;

  logic [DATA_W-1:0] act_o    [ROWS][COLS];
  logic              ve_o     [ROWS][COLS];
  logic [DATA_W-1:0] ps_o     [ROWS][COLS];
  logic              vs_o     [ROWS][COLS];
  logic [DATA_W-1:0] sh_o     [ROWS][COLS];
  logic              sw_o     [ROWS][COLS];

  logic [COLS*DATA_W-1:0] data_out;
  logic [COLS-1:0]        valid_out;

  // Column c is enabled when c < k; any k beyond COLS naturally enables every column.
  always_comb begin
    col_mask_d = col_mask_q;
    if (bus.ub_rd_col_size_valid_in) begin
      for (int c = 0; c < COLS; c++) begin
        col_mask_d[c] = (int'(bus.ub_rd_col_size_in) > c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) col_mask_q <= '0;
    else     col_mask_q <= col_mask_d;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W-1:0] act_in;
      logic [DATA_W-1:0] psum_in;
      logic [DATA_W-1:0] shadow_in;
      logic              valid_in;
      logic              switch_in;

      if (c == 0) begin : g_west
        assign act_in   = bus.sys_data_in[r*DATA_W +: DATA_W];
        assign valid_in = bus.sys_valid_in[r];
      end else begin : g_east
        assign act_in   = act_o[r][c-1];
        assign valid_in = ve_o[r][c-1];
      end

      if (r == 0) begin : g_north
        assign psum_in   = '0;
        assign shadow_in = bus.sys_weight_in[c*DATA_W +: DATA_W];
      end else begin : g_south
        assign psum_in   = ps_o[r-1][c];
        assign shadow_in = sh_o[r-1][c];
      end

      // Switch travels down column 0, then east along each row: PE(r,c) sees it r+c edges late.
      if (r == 0 && c == 0) begin : g_sw_origin
        assign switch_in = bus.sys_switch_in;
      end else if (c == 0) begin : g_sw_down
        assign switch_in = sw_o[r-1][0];
      end else begin : g_sw_east
        assign switch_in = sw_o[r][c-1];
      end

      systolic_pe #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
      ) u_pe (
        .clk         (clk),
        .rst         (rst),
        .col_en      (col_mask_q[c]),
        .act_in      (act_in),
        .valid_in    (valid_in),
        .psum_in     (psum_in),
        .switch_in   (switch_in),
        .accept      (bus.sys_accept_w[c]),
        .shadow_in   (shadow_in),
        .act_out     (act_o[r][c]),
        .valid_east  (ve_o[r][c]),
        .psum_out    (ps_o[r][c]),
        .valid_south (vs_o[r][c]),
        .shadow_out  (sh_o[r][c]),
        .switch_out  (sw_o[r][c])
      );
    end
  end

  always_comb begin
    data_out  = '0;
    valid_out = '0;
    for (int c = 0; c < COLS; c++) begin
      data_out[c*DATA_W +: DATA_W] = ps_o[ROWS-1][c];
      valid_out[c]                 = vs_o[ROWS-1][c];
    end
  end

  assign bus.sys_data_out  = data_out;
  assign bus.sys_valid_out = valid_out;

endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for the 4x4 systolic array with hand-computed Q8.8 results.
module tb_systolic_array;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int CSW    = $clog2(COLS + 1);
  localparam int MAXV   = 32;
  localparam int MAXS   = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  systolic_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) bus ();

  systolic_array #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [DATA_W-1:0] vec_mem  [MAXV][ROWS];
  logic [DATA_W-1:0] exp_mem  [MAXV][COLS];
  logic [COLS-1:0]   en_mask;
  logic              sw_sched  [MAXS];
  logic [COLS-1:0]   acc_sched [MAXS];
  logic [DATA_W-1:0] wt_sched  [MAXS];
  logic [DATA_W-1:0] wload     [ROWS][COLS];
  logic [DATA_W-1:0] ovf_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vectors++;
    assert (observed === expected) else begin
      n_miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    bus.sys_data_in             = '0;
    bus.sys_valid_in            = '0;
    bus.sys_weight_in           = '0;
    bus.sys_accept_w            = '0;
    bus.sys_switch_in           = 1'b0;
    bus.ub_rd_col_size_in       = '0;
    bus.ub_rd_col_size_valid_in = 1'b0;
  endtask

  task automatic clearSched();
    for (int s = 0; s < MAXS; s++) begin
      sw_sched[s]  = 1'b0;
      acc_sched[s] = '0;
      wt_sched[s]  = '0;
    end
  endtask

  task automatic setMask(input logic [CSW-1:0] k);
    bus.ub_rd_col_size_in       = k;
    bus.ub_rd_col_size_valid_in = 1'b1;
    tick();
    bus.ub_rd_col_size_valid_in = 1'b0;
  endtask

  // Push wload so that PE(r,c) ends up holding wload[r][c]: the bottom row goes in first.
  task automatic loadWeights();
    for (int j = 0; j < ROWS; j++) begin
      bus.sys_accept_w = '1;
      for (int c = 0; c < COLS; c++) bus.sys_weight_in[c*DATA_W +: DATA_W] = wload[ROWS-1-j][c];
      tick();
    end
    bus.sys_accept_w  = '0;
    bus.sys_weight_in = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, 64'(bus.sys_valid_out), 64'(0));
    checkOutput({tag, " data"}, 64'(bus.sys_data_out), 64'(0));
  endtask

  // Streams nvec pre-skewed vectors and checks every column on every cycle against exp_mem.
  task automatic applyStimulus(input string name, input int nvec);
    int nsteps;
    int idx;
    logic exp_v;
    logic [DATA_W-1:0] exp_d;
    nsteps = nvec + ROWS + COLS;
    for (int s = 0; s < nsteps; s++) begin
      for (int r = 0; r < ROWS; r++) begin
        idx = s - r;
        if (idx >= 0 && idx < nvec) begin
          bus.sys_data_in[r*DATA_W +: DATA_W] = vec_mem[idx][r];
          bus.sys_valid_in[r]                 = 1'b1;
        end else begin
          bus.sys_data_in[r*DATA_W +: DATA_W] = '0;
          bus.sys_valid_in[r]                 = 1'b0;
        end
      end
      bus.sys_switch_in = sw_sched[s];
      bus.sys_accept_w  = acc_sched[s];
      for (int c = 0; c < COLS; c++) bus.sys_weight_in[c*DATA_W +: DATA_W] = wt_sched[s];
      tick();
      for (int c = 0; c < COLS; c++) begin
        idx   = s - (ROWS + c - 1);
        exp_v = (idx >= 0 && idx < nvec) && en_mask[c];
        exp_d = exp_v ? exp_mem[idx][c] : '0;
        checkOutput($sformatf("%s valid s%0d c%0d", name, s, c), 64'(bus.sys_valid_out[c]), 64'(exp_v));
        checkOutput($sformatf("%s data s%0d c%0d", name, s, c),
                    64'(bus.sys_data_out[c*DATA_W +: DATA_W]), 64'(exp_d));
      end
    end
    idleInputs();
    clearSched();
  endtask

  initial begin
    idleInputs();
    clearSched();
    rst = 1'b1;
    $display("[TB] reset");
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();
    checkAllZero("post reset idle");

    $display("[TB] identity 4x4");
    setMask(CSW'(4));
    en_mask = 4'b1111;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wload[r][c] = (r == c) ? 16'h0100 : 16'h0000;
    loadWeights();
    vec_mem[0][0] = 16'h0100; vec_mem[0][1] = 16'h0200;
    vec_mem[0][2] = 16'h0300; vec_mem[0][3] = 16'h0400;
    exp_mem[0][0] = 16'h0100; exp_mem[0][1] = 16'h0200;
    exp_mem[0][2] = 16'h0300; exp_mem[0][3] = 16'h0400;
    sw_sched[0] = 1'b1;
    applyStimulus("identity", 1);

    $display("[TB] accept and switch on the same edge");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wload[r][c] = 16'h0100;
    loadWeights();
    for (int r = 0; r < ROWS; r++) vec_mem[0][r] = 16'h0100;
    for (int c = 0; c < COLS; c++) exp_mem[0][c] = 16'h0400;
    sw_sched[0]  = 1'b1;
    acc_sched[0] = 4'b0001;
    wt_sched[0]  = 16'h0300;
    applyStimulus("acc_sw", 1);

    $display("[TB] double buffer, back to back");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wload[r][c] = 16'h0100;
    loadWeights();
    for (int v = 0; v < 16; v++) begin
      for (int r = 0; r < ROWS; r++) vec_mem[v][r] = 16'h0100;
      for (int c = 0; c < COLS; c++) exp_mem[v][c] = (v < 8) ? 16'h0400 : 16'h0800;
    end
    sw_sched[0] = 1'b1;
    sw_sched[8] = 1'b1;
    for (int c = 0; c < COLS; c++)
      for (int s = 4 + c; s <= 7 + c; s++) begin
        acc_sched[s][c] = 1'b1;
        wt_sched[s]     = 16'h0200;
      end
    applyStimulus("dbuf", 16);

    $display("[TB] column size k=2");
    setMask(CSW'(2));
    en_mask = 4'b0011;
    for (int v = 0; v < 2; v++) begin
      for (int r = 0; r < ROWS; r++) vec_mem[v][r] = 16'h0100;
      for (int c = 0; c < COLS; c++) exp_mem[v][c] = 16'h0800;
    end
    applyStimulus("k2", 2);

    $display("[TB] overflow with clamped k");
    setMask(CSW'(7));
    en_mask = 4'b1111;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wload[r][c] = 16'h0200;
    loadWeights();
`ifdef SYSTOLIC_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'hF800;
`endif
    for (int r = 0; r < ROWS; r++) vec_mem[0][r] = 16'h7F00;
    for (int c = 0; c < COLS; c++) exp_mem[0][c] = ovf_exp;
    sw_sched[0] = 1'b1;
    applyStimulus("overflow", 1);

    $display("[TB] reset mid-stream");
    for (int s = 0; s < 6; s++) begin
      bus.sys_valid_in = '1;
      for (int r = 0; r < ROWS; r++) bus.sys_data_in[r*DATA_W +: DATA_W] = 16'h0100;
      tick();
    end
    rst = 1'b1;
    tick();
    checkAllZero("rst edge 1");
    tick();
    checkAllZero("rst edge 2");
    rst = 1'b0;
    idleInputs();
    for (int s = 0; s < 8; s++) begin
      tick();
      checkAllZero($sformatf("after rst s%0d", s));
    end
    en_mask = 4'b0000;
    for (int r = 0; r < ROWS; r++) vec_mem[0][r] = 16'h0100;
    for (int c = 0; c < COLS; c++) exp_mem[0][c] = 16'h0000;
    applyStimulus("mask cleared", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
